// File: rtl/reg_lock_scoreboard.sv
// Register-lock scoreboard: per-register in-flight write counters, jump lock and flush.
// Define REG_LOCK_SCOREBOARD_UNDERFLOW_CHK_EN to enable the sticky underflow error.
package rv64g_pkg;
  localparam int NUM_REGS = 32;
endpackage

module reg_lock_scoreboard
  import rv64g_pkg::*;
#(
  parameter int NR      = NUM_REGS,
  parameter int NUM_WB  = 2,
  parameter int MAX_OUT = 3
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         pl_valid_i,
  output logic                         pl_ready_o,
  input  logic                         jump_i,
  input  logic [$clog2(NR)-1:0]        rd_i,
  input  logic [NR-1:0]                reg_req_i,
  input  logic [NUM_WB-1:0]            wb_valid_i,
  input  logic [NUM_WB*$clog2(NR)-1:0] wb_rd_i,
  input  logic                         jump_done_i,
  input  logic                         flush_i,
  output logic [NR-1:0]                locks_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int AW = $clog2(NR);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int EW = CW + $clog2(NUM_WB + 1) + 1;

  typedef enum logic {
    RUN   = 1'b0,
    JLOCK = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt     [NR];
  logic [CW-1:0] w_cnt_nxt [NR];
  logic [NR-1:0] w_nz;
  logic          w_jlock;
  logic          w_rd_full;
  logic          w_fire;
`ifdef REG_LOCK_SCOREBOARD_UNDERFLOW_CHK_EN
  logic [NR-1:0] w_under;
`endif

  assign w_jlock = (r_state == JLOCK);

  always_comb begin
    w_nz = '0;
    for (int r = 1; r < NR; r++) begin
      w_nz[r] = (r_cnt[r] != '0);
    end
  end

  // Jump lock reports all-ones, including the hard-wired register 0.
  assign locks_o = w_nz | {NR{w_jlock}};
  assign busy_o  = |w_nz;

  assign w_rd_full  = (rd_i != '0) && (r_cnt[rd_i] == CW'(MAX_OUT));
  assign pl_ready_o = !w_jlock
                    && !(|(reg_req_i & locks_o))
                    && !w_rd_full
                    && !flush_i
                    && !arst_i;
  assign w_fire = pl_valid_i & pl_ready_o;

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        RUN:     if (w_fire && jump_i) w_state_nxt = JLOCK;
        JLOCK:   if (jump_done_i) w_state_nxt = RUN;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // Issue and all writeback ports net together; underflow saturates at 0.
  always_comb begin
    logic [EW-1:0] v_net;
    logic [EW-1:0] v_dec;
`ifdef REG_LOCK_SCOREBOARD_UNDERFLOW_CHK_EN
    w_under = '0;
`endif
    for (int r = 0; r < NR; r++) begin
      v_dec = '0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid_i[p] && (wb_rd_i[p*AW +: AW] == AW'(r))) begin
          v_dec = v_dec + EW'(1);
        end
      end
      v_net = EW'(r_cnt[r])
            + EW'(w_fire && (rd_i == AW'(r)));
      if (r == 0) begin
        w_cnt_nxt[r] = '0;
      end else if (v_net < v_dec) begin
        w_cnt_nxt[r] = '0;
`ifdef REG_LOCK_SCOREBOARD_UNDERFLOW_CHK_EN
        w_under[r] = 1'b1;
`endif
      end else begin
        w_cnt_nxt[r] = CW'(v_net - v_dec);
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= RUN;
      for (int r = 0; r < NR; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      for (int r = 0; r < NR; r++) begin
        r_cnt[r] <= flush_i ? '0 : w_cnt_nxt[r];
      end
    end
  end

`ifdef REG_LOCK_SCOREBOARD_UNDERFLOW_CHK_EN
  logic r_err;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_err <= 1'b0;
    end else if (!flush_i && (|w_under)) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!arst_i && !flush_i) begin
      for (int r = 0; r < NR; r++) begin
        assert (!w_under[r])
          else $warning("reg_lock_scoreboard: underflow on x%0d", r);
      end
    end
  end
`endif
`else
  assign err_o = 1'b0;
`endif

endmodule
